urng_taus48: RTL and testbench

- Uniform random source that produces the 48-bit `u0` operand consumed by the `log` stage of the AWGN datapath.
- Also produces a 16-bit `u1` word for the sin/cos stage.
- Built from a combined three-component 32-bit Tausworthe generator (taus88). Two consecutive 32-bit outputs are packed into one `{u0,u1}` sample.
- Delivers samples over a valid/ready handshake; reseedable at run time.

---
 rtl/urng_taus48_if.sv | 22 ++
 rtl/urng_taus48.sv | 106 ++++++++++
 tb/tb_urng_taus48.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/urng_taus48_if.sv
// Sample/seed channel of the taus88 uniform source: the generator drives the
// sample side, the consumer drives the seed and ready side.
interface urng_taus48_if;
    logic        seed_load;
    logic [95:0] seed_in;
    logic        seed_err;
    logic [47:0] u0;
    logic [15:0] u1;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sample_cnt;

    modport master (
        input  seed_load, seed_in, out_ready,
        output seed_err, u0, u1, out_valid, sample_cnt
    );

    modport slave (
        output seed_load, seed_in, out_ready,
        input  seed_err, u0, u1, out_valid, sample_cnt
    );
endinterface

// File: rtl/urng_taus48.sv
// Combined three-component Tausworthe (taus88) uniform source: two 32-bit words
// per sample, packed into {u0[47:0], u1[15:0]}, delivered over valid/ready.
module urng_taus48 #(
    parameter logic [31:0] SEED0 = 32'd12345,
    parameter logic [31:0] SEED1 = 32'd67890,
    parameter logic [31:0] SEED2 = 32'd13579
) (
    input logic           clk,
    input logic           rst,
    urng_taus48_if.master urng_if
);

    typedef enum logic [1:0] {GEN_A, GEN_B, HOLD} state_e;

    state_e      state_q;
    logic [31:0] s0_q, s1_q, s2_q;
    logic [31:0] word_a_q;
    logic [47:0] u0_q;
    logic [15:0] u1_q;
    logic        valid_q;
    logic        seed_err_q;
    logic [31:0] sample_cnt_q;

    logic [31:0] b0, b1, b2;
    logic [31:0] s0_d, s1_d, s2_d, word_d;
    logic [31:0] ld_s0, ld_s1, ld_s2;
    logic        ld_err;

    // One taus88 step; shifts drop bits past 32 by construction of the widths.
    assign b0     = ((s0_q << 13) ^ s0_q) >> 19;
    assign s0_d   = ((s0_q & 32'hFFFF_FFFE) << 12) ^ b0;
    assign b1     = ((s1_q << 2) ^ s1_q) >> 25;
    assign s1_d   = ((s1_q & 32'hFFFF_FFF8) << 4) ^ b1;
    assign b2     = ((s2_q << 3) ^ s2_q) >> 11;
    assign s2_d   = ((s2_q & 32'hFFFF_FFF0) << 17) ^ b2;
    assign word_d = s0_d ^ s1_d ^ s2_d;

    // Components below their minimum would collapse the generator to a fixed point.
    assign ld_s0  = (urng_if.seed_in[31:0]  < 32'd2)  ? SEED0 : urng_if.seed_in[31:0];
    assign ld_s1  = (urng_if.seed_in[63:32] < 32'd8)  ? SEED1 : urng_if.seed_in[63:32];
    assign ld_s2  = (urng_if.seed_in[95:64] < 32'd16) ? SEED2 : urng_if.seed_in[95:64];
    assign ld_err = (urng_if.seed_in[31:0] < 32'd2) || (urng_if.seed_in[63:32] < 32'd8) ||
                    (urng_if.seed_in[95:64] < 32'd16);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= GEN_A;
            s0_q         <= SEED0;
            s1_q         <= SEED1;
            s2_q         <= SEED2;
            word_a_q     <= '0;
            u0_q         <= '0;
            u1_q         <= '0;
            valid_q      <= 1'b0;
            seed_err_q   <= 1'b0;
            sample_cnt_q <= '0;
        end else begin
            seed_err_q <= 1'b0;
            // A seed load wins over everything, including a transfer in HOLD.
            if (urng_if.seed_load) begin
                s0_q       <= ld_s0;
                s1_q       <= ld_s1;
                s2_q       <= ld_s2;
                valid_q    <= 1'b0;
                seed_err_q <= ld_err;
                state_q    <= GEN_A;
            end else begin
                unique case (state_q)
                    GEN_A: begin
                        s0_q     <= s0_d;
                        s1_q     <= s1_d;
                        s2_q     <= s2_d;
                        word_a_q <= word_d;
                        state_q  <= GEN_B;
                    end
                    GEN_B: begin
                        s0_q    <= s0_d;
                        s1_q    <= s1_d;
                        s2_q    <= s2_d;
                        u0_q    <= {word_a_q, word_d[31:16]};
                        u1_q    <= word_d[15:0];
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end
                    HOLD: begin
                        if (urng_if.out_ready) begin
                            valid_q      <= 1'b0;
                            sample_cnt_q <= sample_cnt_q + 32'd1;
                            state_q      <= GEN_A;
                        end
                    end
                    default: state_q <= GEN_A;
                endcase
            end
        end
    end

    assign urng_if.u0         = u0_q;
    assign urng_if.u1         = u1_q;
    assign urng_if.out_valid  = valid_q;
    assign urng_if.seed_err   = seed_err_q;
    assign urng_if.sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_urng_taus48.sv
// Scoreboard bench for urng_taus48: a taus88 reference model queues expected
// samples when seeds are applied and each DUT sample is popped and compared.
module tb_urng_taus48;

    localparam logic [31:0] SEED0 = 32'd12345;
    localparam logic [31:0] SEED1 = 32'd67890;
    localparam logic [31:0] SEED2 = 32'd13579;

    logic clk = 1'b0;
    logic rst = 1'b1;

    urng_taus48_if bus_if();

    urng_taus48 #(.SEED0(SEED0), .SEED1(SEED1), .SEED2(SEED2)) dut (
        .clk     (clk),
        .rst     (rst),
        .urng_if (bus_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_s0, m_s1, m_s2;
    logic [63:0] exp_q[$];
    int          exp_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_word(output logic [31:0] w);
        logic [31:0] b;
        b    = ((m_s0 << 13) ^ m_s0) >> 19;
        m_s0 = ((m_s0 & 32'hFFFFFFFE) << 12) ^ b;
        b    = ((m_s1 << 2) ^ m_s1) >> 25;
        m_s1 = ((m_s1 & 32'hFFFFFFF8) << 4) ^ b;
        b    = ((m_s2 << 3) ^ m_s2) >> 11;
        m_s2 = ((m_s2 & 32'hFFFFFFF0) << 17) ^ b;
        w    = m_s0 ^ m_s1 ^ m_s2;
    endtask

    task automatic push_next();
        logic [31:0] wa, wb;
        model_word(wa);
        model_word(wb);
        exp_q.push_back({wa, wb});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_if.seed_load = 1'b0;
        bus_if.seed_in   = '0;
        bus_if.out_ready = 1'b0;
        @(negedge clk);
        check("rst_valid", bus_if.out_valid, 0);
        check("rst_u0", bus_if.u0, 0);
        check("rst_u1", bus_if.u1, 0);
        check("rst_cnt", bus_if.sample_cnt, 0);
        check("rst_err", bus_if.seed_err, 0);
        m_s0 = SEED0; m_s1 = SEED1; m_s2 = SEED2;
        exp_cnt = 0;
        exp_q.delete();
        push_next();
        rst = 1'b0;
    endtask

    task automatic load_seed(input logic [31:0] s2, input logic [31:0] s1, input logic [31:0] s0);
        logic bad;
        bad = (s0 < 2) || (s1 < 8) || (s2 < 16);
        bus_if.seed_load = 1'b1;
        bus_if.seed_in   = {s2, s1, s0};
        @(negedge clk);
        bus_if.seed_load = 1'b0;
        check("load_err", bus_if.seed_err, bad);
        check("load_valid", bus_if.out_valid, 0);
        check("load_cnt", bus_if.sample_cnt, exp_cnt);
        m_s0 = (s0 < 2)  ? SEED0 : s0;
        m_s1 = (s1 < 8)  ? SEED1 : s1;
        m_s2 = (s2 < 16) ? SEED2 : s2;
        exp_q.delete();
        push_next();
    endtask

    task automatic expect_sample(input string tag, output int lat);
        logic [63:0] smp;
        lat = 0;
        while (!bus_if.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_valid"}, bus_if.out_valid, 1);
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 0, 1);
        end else begin
            smp = exp_q.pop_front();
            check({tag, "_u0"}, bus_if.u0, smp[63:16]);
            check({tag, "_u1"}, bus_if.u1, smp[15:0]);
            push_next();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int last;
        int transfers;
        logic [63:0] smp;

        // Minimal seeds: known first sample, 2-cycle latency, one transfer.
        do_reset();
        bus_if.out_ready = 1'b1;
        load_seed(32'd16, 32'd8, 32'd2);
        expect_sample("t1", lat);
        check("t1_latency", lat, 2);
        check("t1_u0_const", bus_if.u0, 48'h0020_2080_0200);
        check("t1_u1_const", bus_if.u1, 16'h2C80);
        @(negedge clk);
        exp_cnt++;
        check("t1_cnt", bus_if.sample_cnt, exp_cnt);
        check("t1_valid_drop", bus_if.out_valid, 0);

        // Back-pressure: sample held stable for 10 cycles, then exactly one transfer.
        do_reset();
        load_seed(32'd16, 32'd8, 32'd2);
        expect_sample("t2", lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t2_hold_valid", bus_if.out_valid, 1);
            check("t2_hold_u0", bus_if.u0, 48'h0020_2080_0200);
            check("t2_hold_u1", bus_if.u1, 16'h2C80);
            check("t2_hold_cnt", bus_if.sample_cnt, 0);
        end
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        bus_if.out_ready = 1'b0;
        exp_cnt++;
        check("t2_cnt", bus_if.sample_cnt, 1);
        check("t2_valid_drop", bus_if.out_valid, 0);
        expect_sample("t2b", lat);
        @(negedge clk);
        check("t2b_cnt", bus_if.sample_cnt, exp_cnt);

        // Invalid s0 and s2 fall back to their defaults; error is a 1-cycle pulse.
        load_seed(32'd5, 32'd8, 32'd0);
        @(negedge clk);
        check("t3_err_pulse", bus_if.seed_err, 0);
        expect_sample("t3", lat);

        // Seed load during GEN_B, then during HOLD with out_ready high.
        load_seed(32'd16, 32'd8, 32'd2);
        @(negedge clk);
        load_seed(32'd100, 32'd200, 32'd300);
        @(negedge clk);
        check("t4a_valid", bus_if.out_valid, 0);
        expect_sample("t4a", lat);
        check("t4a_cnt", bus_if.sample_cnt, exp_cnt);
        bus_if.out_ready = 1'b1;
        load_seed(32'd1000, 32'd2000, 32'd3000);
        bus_if.out_ready = 1'b0;
        check("t4b_cnt", bus_if.sample_cnt, exp_cnt);
        expect_sample("t4b", lat);

        // Free-running stream from default seeds.
        do_reset();
        bus_if.out_ready = 1'b1;
        last = -1;
        transfers = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus_if.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("t5_queue", 0, 1);
                end else begin
                    smp = exp_q.pop_front();
                    check("t5_u0", bus_if.u0, smp[63:16]);
                    check("t5_u1", bus_if.u1, smp[15:0]);
                    push_next();
                end
                if (last >= 0) check("t5_cadence", i - last, 3);
                last = i;
                transfers++;
                exp_cnt++;
            end
        end
        check("t5_transfers", transfers, 1000);
        check("t5_cnt", bus_if.sample_cnt, exp_cnt);

        // Counter wrap.
        bus_if.out_ready = 1'b0;
        expect_sample("t6", lat);
        force dut.sample_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.sample_cnt_q;
        check("t6_preload", bus_if.sample_cnt, 32'hFFFF_FFFF);
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        bus_if.out_ready = 1'b0;
        check("t6_wrap", bus_if.sample_cnt, 0);

        // Asynchronous reset mid-HOLD, checked before any clock edge.
        expect_sample("t7", lat);
        #2;
        rst = 1'b1;
        #1;
        check("t7_valid", bus_if.out_valid, 0);
        check("t7_u0", bus_if.u0, 0);
        check("t7_u1", bus_if.u1, 0);
        check("t7_cnt", bus_if.sample_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
